// File: rtl/sseg_frame_decoder_pkg.sv
// sseg_pkg: shared constants for the seven-segment frame decoder.
//   CH_*   : 4-bit character codes reported in frame_data
//   SEG_*  : active-low {g,f,e,d,c,b,a} glyph patterns
//   state_t: frame assembly FSM states
package sseg_pkg;
    localparam logic [3:0] CH_O     = 4'd0;
    localparam logic [3:0] CH_T     = 4'd1;
    localparam logic [3:0] CH_BLANK = 4'd2;
    localparam logic [3:0] CH_E     = 4'd3;
    localparam logic [3:0] CH_H     = 4'd4;
    localparam logic [3:0] CH_L     = 4'd7;
    localparam logic [3:0] CH_R     = 4'd8;
    localparam logic [3:0] CH_BAD   = 4'hF;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_T     = 7'b0000111;
    localparam logic [6:0] SEG_R     = 7'b0001000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    typedef enum logic {COLLECT, PRESENT} state_t;
endpackage

// File: rtl/sseg_frame_decoder_if.sv
// sseg_frame_if: valid/ready frame bus between the decoder and its consumer.
//   frame_valid/frame_ready : handshake
//   frame_data  : {digit3, digit2, digit1, digit0} character codes
//   frame_dp    : per-digit decimal point, 1 = lit
//   frame_err   : frame holds at least one unknown glyph
//   frame_changed: frame_data differs from the previously accepted frame
interface sseg_frame_if;
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] frame_data;
    logic [3:0]  frame_dp;
    logic        frame_err;
    logic        frame_changed;
    modport master (output frame_valid, frame_data, frame_dp, frame_err, frame_changed, input frame_ready);
    modport slave  (input frame_valid, frame_data, frame_dp, frame_err, frame_changed, output frame_ready);
endinterface

// File: rtl/sseg_frame_decoder_char_decode.sv
// sseg_char_decode: maps an active-low segment pattern to its character code.
//   seg_n : {g,f,e,d,c,b,a}, active-low
//   code  : character code, CH_BAD for unknown glyphs
//   err   : high for unknown glyphs
module sseg_char_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] code,
    output logic       err
);
    assign code = seg_n == SEG_H     ? CH_H     :
                  seg_n == SEG_E     ? CH_E     :
                  seg_n == SEG_L     ? CH_L     :
                  seg_n == SEG_O     ? CH_O     :
                  seg_n == SEG_T     ? CH_T     :
                  seg_n == SEG_R     ? CH_R     :
                  seg_n == SEG_BLANK ? CH_BLANK : CH_BAD;
    assign err = code == CH_BAD;
endmodule

// File: rtl/sseg_frame_decoder.sv
// sseg_frame_decoder: samples a multiplexed 4-digit seven-segment bus and
// rebuilds complete frames of character codes on a valid/ready interface.
//   clock, reset  : system clock, asynchronous active-high reset
//   seg_n, dp_n   : active-low segment lines and decimal point
//   an_n          : active-low anodes, an_n[0] = rightmost digit
//   frame         : sseg_frame_if master (valid/ready frame bus)
//   frame_dropped : sticky, a completed frame was lost while one was pending
//   timeout       : one-cycle pulse when no digit was accepted for TIMEOUT_CYCLES
// Build option SSEG_DP_CAPTURE_EN: capture decimal points into frame_dp;
// when undefined dp_n is ignored and frame_dp reads 0.
module sseg_frame_decoder
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
)
(
    input  logic         clock,
    input  logic         reset,
    input  logic [6:0]   seg_n,
    input  logic         dp_n,
    input  logic [3:0]   an_n,
    sseg_frame_if.master frame,
    output logic         frame_dropped,
    output logic         timeout
);
    localparam int SCW = $clog2(STABLE_CYCLES);
    localparam int TCW = $clog2(TIMEOUT_CYCLES);
`ifdef SSEG_DP_CAPTURE_EN
    localparam int PW = 12;
    logic [PW-1:0] pins;
    logic [3:0]    dp_q, nxt_dp, fdp;
    assign pins = {an_n, seg_n, dp_n};
    assign frame.frame_dp = fdp;
`else
    localparam int PW = 11;
    logic [PW-1:0] pins;
    logic          unused_dp;
    assign pins = {an_n, seg_n};
    assign unused_dp = dp_n;
    assign frame.frame_dp = 4'h0;
`endif
    logic [PW-1:0]   s1, s2, prev;
    logic [SCW-1:0]  stab_q;
    logic [TCW-1:0]  act_q;
    logic            taken, stable, accept, complete, act_max, hs, chg, derr, has_last;
    logic [3:0]      seen, sel, nxt_seen, err_q, nxt_err, dcode;
    logic [3:0][3:0] code_q, nxt_code;
    logic [15:0]     last_q;
    state_t          state;

    // prev is the settled sample; sel is the one-hot digit position it addresses
    assign sel      = ~prev[PW-1 -: 4];
    assign stable   = stab_q == SCW'(STABLE_CYCLES - 1);
    assign accept   = stable && !taken && $onehot(sel);
    assign act_max  = act_q == TCW'(TIMEOUT_CYCLES - 1);
    assign nxt_seen = seen | (accept ? sel : 4'h0);
    assign complete = accept && &nxt_seen;
    assign hs       = frame.frame_valid && frame.frame_ready;
    // a frame loaded in the same cycle as a handshake compares against the frame being accepted
    assign chg      = !(hs || has_last) || nxt_code != (hs ? frame.frame_data : last_q);

    sseg_char_decode u_dec (.seg_n(prev[PW-5 -: 7]), .code(dcode), .err(derr));

    always_comb begin
        nxt_code = code_q;
        nxt_err  = err_q;
`ifdef SSEG_DP_CAPTURE_EN
        nxt_dp   = dp_q;
`endif
        for (int i = 0; i < 4; i++) begin
            if (accept && sel[i]) begin
                nxt_code[i] = dcode;
                nxt_err[i]  = derr;
`ifdef SSEG_DP_CAPTURE_EN
                nxt_dp[i]   = ~prev[0];
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1      <= '1;
            s2      <= '1;
            prev    <= '1;
            stab_q  <= '0;
            act_q   <= '0;
            taken   <= 1'b0;
            timeout <= 1'b0;
            seen    <= '0;
            code_q  <= '0;
            err_q   <= '0;
`ifdef SSEG_DP_CAPTURE_EN
            dp_q    <= '0;
`endif
        end else begin
            s1      <= pins;
            s2      <= s1;
            prev    <= s2;
            stab_q  <= s2 != prev ? '0 : stable ? stab_q : stab_q + 1'b1;
            taken   <= s2[PW-1 -: 4] != prev[PW-1 -: 4] ? 1'b0 : accept ? 1'b1 : taken;
            act_q   <= accept || act_max ? '0 : act_q + 1'b1;
            timeout <= act_max && !accept;
            seen    <= complete || (act_max && !accept) ? '0 : nxt_seen;
            code_q  <= nxt_code;
            err_q   <= nxt_err;
`ifdef SSEG_DP_CAPTURE_EN
            dp_q    <= nxt_dp;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= COLLECT;
            frame.frame_valid   <= 1'b0;
            frame.frame_data    <= '0;
            frame.frame_err     <= 1'b0;
            frame.frame_changed <= 1'b0;
            frame_dropped       <= 1'b0;
            last_q              <= '0;
            has_last            <= 1'b0;
`ifdef SSEG_DP_CAPTURE_EN
            fdp                 <= '0;
`endif
        end else begin
            if (hs) begin
                last_q        <= frame.frame_data;
                has_last      <= 1'b1;
                frame_dropped <= 1'b0;
            end
            if (complete && (state == COLLECT || hs)) begin
                state               <= PRESENT;
                frame.frame_valid   <= 1'b1;
                frame.frame_data    <= nxt_code;
                frame.frame_err     <= |nxt_err;
                frame.frame_changed <= chg;
`ifdef SSEG_DP_CAPTURE_EN
                fdp                 <= nxt_dp;
`endif
            end else if (complete) begin
                frame_dropped <= 1'b1;
            end else if (hs) begin
                state             <= COLLECT;
                frame.frame_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sseg_frame_decoder.sv
// tb_sseg_frame_decoder: scan-driven bench with a frame-level reference model.
module tb_sseg_frame_decoder;
    localparam int STABLE = 16;
    localparam int TMO    = 1024;
    localparam int DWELL  = 64;
    localparam logic [6:0] P_H = 7'b0001001, P_E = 7'b0000110, P_L = 7'b1000111, P_O = 7'b1000000;
    localparam logic [6:0] P_T = 7'b0000111, P_R = 7'b0001000, P_B = 7'b1111111;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        err;
        logic        chg;
    } frm_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [6:0] seg_n = '1;
    logic dp_n = 1'b1;
    logic [3:0] an_n = '1;
    logic frame_dropped, timeout;
    sseg_frame_if fif();

    sseg_frame_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
        .frame(fif), .frame_dropped(frame_dropped), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int n_pass = 0, n_total = 0, n_hs = 0, n_to = 0;
    frm_t exp_q[$];
    frm_t pres_f, last_hs, cmp_f;
    logic [3:0] m_code [4];
    logic [3:0] m_err, m_dp_lit, m_seen;
    logic [15:0] m_last;
    bit m_has_last = 0, m_pres = 0, m_dropped = 0, rdy = 0;
    logic [6:0] glyphs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // {err, code} straight from the glyph table
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        case (p)
            7'b0001001: return {1'b0, 4'd4};
            7'b0000110: return {1'b0, 4'd3};
            7'b1000111: return {1'b0, 4'd7};
            7'b1000000: return {1'b0, 4'd0};
            7'b0000111: return {1'b0, 4'd1};
            7'b0001000: return {1'b0, 4'd8};
            7'b1111111: return {1'b0, 4'd2};
            default:    return {1'b1, 4'hF};
        endcase
    endfunction

    task automatic accept_model(input frm_t f);
        exp_q.push_back(f);
        m_last = f.data;
        m_has_last = 1;
        m_dropped = 0;
    endtask

    task automatic model_digit(input int d, input logic [6:0] p, input logic dpn);
        logic [4:0] r;
        frm_t f;
        r = ref_decode(p);
        m_code[d] = r[3:0];
        m_err[d] = r[4];
        m_dp_lit[d] = ~dpn;
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
            m_seen = 0;
            f.data = {m_code[3], m_code[2], m_code[1], m_code[0]};
`ifdef SSEG_DP_CAPTURE_EN
            f.dp = m_dp_lit;
`else
            f.dp = 4'h0;
`endif
            f.err = |m_err;
            f.chg = !m_has_last || f.data != m_last;
            if (rdy) accept_model(f);
            else if (!m_pres) begin m_pres = 1; pres_f = f; end
            else m_dropped = 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_ready(input bit v);
        if (v && m_pres) begin accept_model(pres_f); m_pres = 0; end
        rdy = v;
        fif.frame_ready = v;
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dpn, input int len);
        an_n = an;
        seg_n = seg;
        dp_n = dpn;
        tick(len);
    endtask

    task automatic idle(input int len);
        drive(4'hF, 7'h7F, 1'b1, len);
    endtask

    task automatic scan(input logic [3:0][6:0] p, input logic [3:0] dpn, input logic [3:0] mask);
        logic [3:0] an;
        for (int d = 3; d >= 0; d--) begin
            if (mask[d]) begin
                an = 4'hF;
                an[d] = 1'b0;
                model_digit(d, p[d], dpn[d]);
                drive(an, p[d], dpn[d], DWELL);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, fif.frame_valid, 0);
        check({tag, "_data"}, fif.frame_data, 16'h0000);
        check({tag, "_dp"}, fif.frame_dp, 4'h0);
        check({tag, "_err"}, fif.frame_err, 0);
        check({tag, "_changed"}, fif.frame_changed, 0);
        check({tag, "_dropped"}, frame_dropped, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (fif.frame_valid && fif.frame_ready) begin
                check("hs_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cmp_f = exp_q.pop_front();
                    check("hs_data", fif.frame_data, cmp_f.data);
                    check("hs_dp", fif.frame_dp, cmp_f.dp);
                    check("hs_err", fif.frame_err, cmp_f.err);
                    check("hs_changed", fif.frame_changed, cmp_f.chg);
                end
                last_hs = {fif.frame_data, fif.frame_dp, fif.frame_err, fif.frame_changed};
                n_hs++;
            end else if (fif.frame_valid) begin
                check("pending_modeled", m_pres, 1);
                check("hold_data", fif.frame_data, pres_f.data);
                check("hold_dp", fif.frame_dp, pres_f.dp);
                check("hold_err", fif.frame_err, pres_f.err);
                check("hold_changed", fif.frame_changed, pres_f.chg);
            end
            if (timeout) n_to++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0][6:0] p;
        logic [6:0] gp;
        glyphs = '{P_H, P_E, P_L, P_O, P_T, P_R, P_B};
        for (int i = 0; i < 4; i++) m_code[i] = 0;
        m_err = 0; m_dp_lit = 0; m_seen = 0; m_last = 0;
        fif.frame_ready = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(5);
        set_ready(1);
        scan({P_H, P_E, P_L, P_L}, 4'hF, 4'hF);
        check("hell_data", last_hs.data, 16'h4377);
        check("hell_changed", last_hs.chg, 1);
        check("hell_err", last_hs.err, 0);
        scan({P_H, P_E, P_L, P_L}, 4'hF, 4'hF);
        check("repeat_changed", last_hs.chg, 0);
        scan({P_E, P_L, P_L, P_O}, 4'hF, 4'hF);
        check("ello_data", last_hs.data, 16'h3770);
        check("ello_changed", last_hs.chg, 1);
        scan({P_H, P_E, 7'b0101010, P_L}, 4'hF, 4'hF);
        check("bad_data", last_hs.data, 16'h43F7);
        check("bad_err", last_hs.err, 1);
        set_ready(0);
        idle(10);
        scan({P_H, P_E, P_L, P_L}, 4'hF, 4'hF);
        scan({P_E, P_L, P_L, P_O}, 4'hF, 4'hF);
        check("held_valid", fif.frame_valid, 1);
        check("held_data", fif.frame_data, 16'h4377);
        check("dropped_set", frame_dropped, 1);
        set_ready(1);
        tick(20);
        check("dropped_clear", frame_dropped, 0);
        check("retained_data", last_hs.data, 16'h4377);
        check("frames_so_far", n_hs, 5);
        idle(30);
        for (int k = 0; k < 4; k++) begin
            gp = 7'($urandom);
            drive(~(4'b0001 << k), gp, 1'($urandom), $urandom_range(3, 12));
            idle(30);
        end
        drive(4'b1100, P_H, 1'b1, DWELL);
        idle(30);
        check("glitch_no_frame", fif.frame_valid, 0);
        scan({P_E, P_L, P_L, P_O}, 4'hF, 4'b1100);
        check("glitch_seen_clean", fif.frame_valid, 0);
        check("glitch_frames", n_hs, 5);
        scan({P_E, P_L, P_L, P_O}, 4'hF, 4'b0011);
        check("after_glitch_data", last_hs.data, 16'h3770);
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                set_ready(!rdy);
                idle(20);
            end
            for (int d = 0; d < 4; d++) p[d] = $urandom_range(0, 7) == 7 ? 7'($urandom) : glyphs[$urandom_range(0, 6)];
            scan(p, 4'($urandom), 4'hF);
            check("rand_dropped", frame_dropped, m_dropped);
        end
        set_ready(1);
        tick(20);
        check("rand_dropped_final", frame_dropped, m_dropped);
        scan({P_H, P_E, P_L, P_L}, 4'hF, 4'hF);
        scan({P_H, P_E, P_L, P_L}, 4'hF, 4'b1100);
        idle(TMO + 100);
        m_seen = 0;
        check("timeout_pulses", n_to, 1);
        check("timeout_no_frame", fif.frame_valid, 0);
        scan({P_E, P_L, P_L, P_O}, 4'hF, 4'b0011);
        check("timeout_cleared_seen", fif.frame_valid, 0);
        drive(4'b0111, P_E, 1'b1, 30);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        m_seen = 0; m_has_last = 0; m_pres = 0; m_dropped = 0; m_last = 0;
        tick(3);
        reset = 1'b0;
        idle(10);
        scan({P_H, P_E, P_L, P_L}, 4'hF, 4'hF);
        check("post_reset_data", last_hs.data, 16'h4377);
        check("post_reset_changed", last_hs.chg, 1);
        idle(10);
        check("queue_drained", exp_q.size(), 0);
        check("timeout_total", n_to, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sseg_frame_decoder.md
# sseg_frame_decoder

- Receive-side counterpart of the team's multiplexed 4-digit seven-segment driver.
- Samples the active-low anode and segment lines and decodes each glyph back to its 4-bit character code.
- Assembles the four digits into a frame and offers it on a valid/ready interface.
- Used as an on-chip monitor or loopback checker for scrolling-text displays, and for capture of an external display bus.

## Interface

Parameters:
- STABLE_CYCLES, 16, consecutive identical samples required before a digit is accepted (min 2).
- TIMEOUT_CYCLES, 1048576, cycles with no accepted digit before the partial frame is discarded and timeout asserts.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- seg_n  in  7  segment lines {g,f,e,d,c,b,a}, active-low
- dp_n  in  1  decimal point, active-low
- an_n  in  4  digit anodes, active-low, an_n[0] = rightmost digit
- frame_valid  out  1  frame_data holds an unaccepted frame
- frame_ready  in  1  consumer accepts when high with frame_valid
- frame_data  out  16  {digit3, digit2, digit1, digit0}, 4-bit codes
- frame_dp  out  4  per-digit decimal point, 1 = lit
- frame_err  out  1  frame contains at least one unknown glyph
- frame_changed  out  1  frame_data differs from the previously accepted frame
- frame_dropped  out  1  sticky; a completed frame was lost while frame_valid was high
- timeout  out  1  one-cycle pulse when the activity counter expires

## Operation

- Input sampling:
  - seg_n, dp_n and an_n pass through a 2-flop synchronizer.
  - A stability counter increments while the synchronized {an_n, seg_n, dp_n} equals the previous sample.
  - It clears on any change and saturates at STABLE_CYCLES-1.
- Digit accept:
  - Occurs when the counter reaches STABLE_CYCLES-1 and an_n is one-hot-low.
  - Exactly one accept per dwell; a "taken" flag blocks re-accept until an_n changes.
  - an_n all-high or multiple-low is never accepted.
- Glyph decode (active-low {g..a}):
  - 0001001 → 4 (H)
  - 0000110 → 3 (E)
  - 1000111 → 7 (L)
  - 1000000 → 0 (O)
  - 0000111 → 1 (T)
  - 0001000 → 8 (R)
  - 1111111 → 2 (blank)
  - anything else → 4'hF, and the slot's err bit is set.
- Slots:
  - An accept writes code, err and dp into the slot selected by an_n and sets that slot's seen bit.
  - Re-capture of an already-seen slot overwrites it with the newest value.
- FSM COLLECT / PRESENT:
  - COLLECT → PRESENT when all four seen bits are set. frame_data, frame_dp and frame_err load from the slots, frame_changed is computed, and seen clears. Collection continues in both states.
  - PRESENT → COLLECT on frame_valid && frame_ready, unless a new frame completes in the same cycle. In that case the new frame loads and frame_valid stays high.
  - A frame completing in PRESENT without ready is discarded and frame_dropped sets.
  - frame_dropped clears on the next acceptance, unless a drop occurs in the same cycle (set wins).
- frame_changed compares against an internal last-accepted register, which updates on acceptance. After reset the first frame reports changed = 1.
- Timeout:
  - The activity counter clears on every accept and counts otherwise.
  - At TIMEOUT_CYCLES-1: timeout pulses, seen clears, and the counter restarts.
  - A presented frame is unaffected.

## Timing

- Reset values:
  - frame_valid, frame_err, frame_changed, frame_dropped, timeout = 0
  - frame_data = 16'h0000, frame_dp = 4'h0
  - FSM in COLLECT; seen, taken and all counters = 0
- Accept occurs 2 (sync) + STABLE_CYCLES-1 cycles after a pattern settles on the pins.
- frame_valid rises the cycle after the fourth slot is accepted.
- frame_data and related outputs are stable while frame_valid && !frame_ready.
- Reset asserted mid-frame clears all state immediately; no partial frame is ever presented.

## Configuration

- SSEG_DP_CAPTURE_EN:
  - Defined: dp_n is synchronized and included in the stability comparison, and frame_dp reports the captured decimal points.
  - Undefined: dp_n is ignored (not synchronized, not compared) and frame_dp is driven 4'h0.

## Structure

- Package sseg_pkg holds:
  - character code localparams (CH_O=0, CH_T=1, CH_BLANK=2, CH_E=3, CH_H=4, CH_L=7, CH_R=8, CH_BAD=4'hF)
  - the seven active-low segment pattern constants
  - FSM state enum
- Sub-module sseg_char_decode: combinational 7-bit pattern → {code, err}, using only package constants.

## Test plan

- Drive a driver-style scan with 64-cycle dwells showing H,E,L,L (digit3..0), ready=1 → one frame, frame_data=16'h4377, frame_err=0, frame_changed=1.
- Repeat the same frame, then the scroll step E,L,L,O → second frame changed=0, third frame 16'h3770 with changed=1.
- Segment pattern 0101010 on digit1 → that nibble = F, frame_err=1.
- Hold ready=0 across two complete scans, then raise ready → first frame retained, frame_dropped=1, and it clears after acceptance.
- Glitch segments for fewer than STABLE_CYCLES cycles, and drive an_n=4'b1100 → no accept, seen unchanged.
- Stop scanning after 2 digits for TIMEOUT_CYCLES → timeout pulse, no frame; then assert reset mid-scan → all outputs return to reset values.
